// File: rtl/mem_bus_pkg.sv
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types and default geometry for the L1-to-memory
//                bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        RBURST = 2'd2,
        WACK   = 2'd3
    } state_e;

    // Identity of the cache that owns the current transaction
    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    // Default line geometry: 8 words per line, 3 word-offset bits
    localparam int c_DEF_OFFSET_BITS    = 3;
    localparam int c_DEF_WORDS_PER_LINE = 8;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way grant between the I-cache and D-cache requests.
//                Default build: round-robin, ptr_dc=1 means the D-cache wins
//                a tie. With MEM_ARB_DPRIO_EN defined the D-cache has fixed
//                priority and the pointer input does not exist.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic ic_valid,
    input  logic dc_valid,
`ifndef MEM_ARB_DPRIO_EN
    input  logic ptr_dc,
`endif
    output logic grant_ic,
    output logic grant_dc
);

`ifdef MEM_ARB_DPRIO_EN
    // D-cache always wins when it asks
    assign grant_dc = dc_valid;
`else
    // D-cache wins if alone, or on a tie when the pointer favours it
    assign grant_dc = dc_valid & (~ic_valid | ptr_dc);
`endif

    assign grant_ic = ic_valid & ~grant_dc;

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one main-memory port between the L1 I-cache
//                (line-fill reads) and L1 D-cache (line-fill reads and
//                single-word stores). One transaction at a time: grant,
//                address handshake, then read burst or write ack.
//  Config      : MEM_ARB_DPRIO_EN - D-cache fixed priority (no RR pointer)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int OFFSET_BITS    = c_DEF_OFFSET_BITS,
    parameter int WORDS_PER_LINE = c_DEF_WORDS_PER_LINE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ic_req_valid,
    input  logic [31:0] ic_req_addr,
    output logic        ic_req_ready,
    output logic        ic_resp_valid,
    output logic [31:0] ic_resp_data,
    output logic        ic_resp_last,
    input  logic        dc_req_valid,
    input  logic        dc_req_we,
    input  logic [31:0] dc_req_addr,
    input  logic [31:0] dc_req_wdata,
    output logic        dc_req_ready,
    output logic        dc_resp_valid,
    output logic [31:0] dc_resp_data,
    output logic        dc_resp_last,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_wack
);

    localparam logic [31:0]            c_LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);
    localparam logic [OFFSET_BITS-1:0] c_BEAT_LAST = OFFSET_BITS'(WORDS_PER_LINE - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    req_id_e                r_owner;
    logic [OFFSET_BITS-1:0] r_beat;
    logic                   r_ic_req_ready, r_dc_req_ready;
    logic                   r_ic_resp_valid, r_ic_resp_last;
    logic                   r_dc_resp_valid, r_dc_resp_last;
    logic [31:0]            r_ic_resp_data, r_dc_resp_data;
    logic                   r_mem_valid, r_mem_we;
    logic [31:0]            r_mem_addr, r_mem_wdata;
    logic                   w_grant_ic, w_grant_dc;
    logic                   w_done;
    logic                   w_start;
    logic                   w_beat_last;

    // A completion pulse is on the bus this cycle: hold off the next grant
    assign w_done      = r_ic_resp_last | r_dc_resp_last;
    assign w_start     = (r_state == IDLE) && !w_done && (ic_req_valid || dc_req_valid);
    assign w_beat_last = (r_beat == c_BEAT_LAST);

`ifdef MEM_ARB_DPRIO_EN
    rr_arb2 u_arb (
        .ic_valid (ic_req_valid),
        .dc_valid (dc_req_valid),
        .grant_ic (w_grant_ic),
        .grant_dc (w_grant_dc)
    );
`else
    logic r_ptr_dc;

    rr_arb2 u_arb (
        .ic_valid (ic_req_valid),
        .dc_valid (dc_req_valid),
        .ptr_dc   (r_ptr_dc),
        .grant_ic (w_grant_ic),
        .grant_dc (w_grant_dc)
    );

    // Round-robin pointer: after each grant, favour the other requester
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr_dc <= 1'b1;
        end else if (w_start) begin
            r_ptr_dc <= w_grant_ic;
        end
    end
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = ADDR;
            ADDR:    if (mem_ready) w_state_nxt = r_mem_we ? WACK : RBURST;
            RBURST:  if (mem_rvalid && w_beat_last) w_state_nxt = IDLE;
            WACK:    if (mem_wack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, memory address phase, beat counter and response registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_owner         <= REQ_DC;
            r_beat          <= '0;
            r_ic_req_ready  <= 1'b0;
            r_dc_req_ready  <= 1'b0;
            r_ic_resp_valid <= 1'b0;
            r_ic_resp_last  <= 1'b0;
            r_ic_resp_data  <= '0;
            r_dc_resp_valid <= 1'b0;
            r_dc_resp_last  <= 1'b0;
            r_dc_resp_data  <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            // Handshake and response strobes are single-cycle pulses
            r_ic_req_ready  <= 1'b0;
            r_dc_req_ready  <= 1'b0;
            r_ic_resp_valid <= 1'b0;
            r_ic_resp_last  <= 1'b0;
            r_ic_resp_data  <= '0;
            r_dc_resp_valid <= 1'b0;
            r_dc_resp_last  <= 1'b0;
            r_dc_resp_data  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mem_valid <= 1'b1;
                        if (w_grant_dc) begin
                            r_owner        <= REQ_DC;
                            r_dc_req_ready <= 1'b1;
                            r_mem_we       <= dc_req_we;
                            r_mem_addr     <= dc_req_we ? dc_req_addr : (dc_req_addr & c_LINE_MASK);
                            r_mem_wdata    <= dc_req_wdata;
                        end else begin
                            r_owner        <= REQ_IC;
                            r_ic_req_ready <= 1'b1;
                            r_mem_we       <= 1'b0;
                            r_mem_addr     <= ic_req_addr & c_LINE_MASK;
                            r_mem_wdata    <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (mem_ready) r_mem_valid <= 1'b0;
                end
                RBURST: begin
                    if (mem_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_owner == REQ_DC) begin
                            r_dc_resp_valid <= 1'b1;
                            r_dc_resp_data  <= mem_rdata;
                            r_dc_resp_last  <= w_beat_last;
                        end else begin
                            r_ic_resp_valid <= 1'b1;
                            r_ic_resp_data  <= mem_rdata;
                            r_ic_resp_last  <= w_beat_last;
                        end
                    end
                end
                WACK: begin
                    if (mem_wack) begin
                        r_dc_resp_valid <= 1'b1;
                        r_dc_resp_last  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ic_req_ready  = r_ic_req_ready;
    assign ic_resp_valid = r_ic_resp_valid;
    assign ic_resp_data  = r_ic_resp_data;
    assign ic_resp_last  = r_ic_resp_last;
    assign dc_req_ready  = r_dc_req_ready;
    assign dc_resp_valid = r_dc_resp_valid;
    assign dc_resp_data  = r_dc_resp_data;
    assign dc_resp_last  = r_dc_resp_last;
    assign mem_valid     = r_mem_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Directed self-checking bench for mem_bus_arbiter.
//                Expectations follow MEM_ARB_DPRIO_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    logic        CLK, RST;
    logic        ic_req_valid, ic_req_ready, ic_resp_valid, ic_resp_last;
    logic [31:0] ic_req_addr, ic_resp_data;
    logic        dc_req_valid, dc_req_we, dc_req_ready, dc_resp_valid, dc_resp_last;
    logic [31:0] dc_req_addr, dc_req_wdata, dc_resp_data;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid, mem_wack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter dut (
        .CLK(CLK), .RST(RST),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
        .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_last(dc_resp_last),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wack(mem_wack)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        ic_req_valid = 0; ic_req_addr = 0;
        dc_req_valid = 0; dc_req_we = 0; dc_req_addr = 0; dc_req_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_wack = 0;
        step;
        step;
        RST = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++;
        if ({ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 000000",
                {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last});
        end
        total++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata} !== 66'b0) begin
            bad++; $display("FAIL reset_mem: got valid=%b we=%b addr=%h wdata=%h want all 0",
                mem_valid, mem_we, mem_addr, mem_wdata);
        end
        step;
        total++;
        if (mem_valid !== 1'b0) begin
            bad++; $display("FAIL idle_no_req: mem_valid got %b want 0", mem_valid);
        end
    endtask

    task automatic test_ic_read;
        ic_req_valid = 1; ic_req_addr = 32'h0000_1234;
        step;
        total++;
        if ({ic_req_ready, dc_req_ready, mem_valid, mem_we, mem_addr} !== {4'b1010, 32'h0000_1230}) begin
            bad++; $display("FAIL ic_grant: got ready=%b/%b valid=%b we=%b addr=%h want 1/0 1 0 00001230",
                ic_req_ready, dc_req_ready, mem_valid, mem_we, mem_addr);
        end
        ic_req_valid = 0; ic_req_addr = 0;
        step;
        total++;
        if ({ic_req_ready, mem_valid, mem_addr} !== {2'b01, 32'h0000_1230}) begin
            bad++; $display("FAIL ic_addr_hold: got ready=%b valid=%b addr=%h want 0 1 00001230",
                ic_req_ready, mem_valid, mem_addr);
        end
        mem_ready = 1;
        step;
        mem_ready = 0;
        total++;
        if (mem_valid !== 1'b0) begin
            bad++; $display("FAIL ic_addr_done: mem_valid got %b want 0", mem_valid);
        end
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1; mem_rdata = i;
            step;
            total++;
            if ({ic_resp_valid, ic_resp_last, ic_resp_data} !== {1'b1, 1'(i == 7), 32'(i)}) begin
                bad++; $display("FAIL ic_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                    i, ic_resp_valid, ic_resp_last, ic_resp_data, (i == 7), i);
            end
            total++;
            if ({dc_resp_valid, dc_resp_last, dc_resp_data} !== 34'b0) begin
                bad++; $display("FAIL ic_beat%0d_dc_quiet: got v=%b l=%b d=%h want 0",
                    i, dc_resp_valid, dc_resp_last, dc_resp_data);
            end
            if (i == 3) begin
                mem_rvalid = 0;
                step;
                total++;
                if (ic_resp_valid !== 1'b0) begin
                    bad++; $display("FAIL ic_gap: ic_resp_valid got %b want 0", ic_resp_valid);
                end
            end
        end
        mem_rvalid = 0;
        step;
        total++;
        if ({ic_resp_valid, ic_resp_last, mem_valid} !== 3'b0) begin
            bad++; $display("FAIL ic_after_burst: got v=%b l=%b mv=%b want 0 0 0",
                ic_resp_valid, ic_resp_last, mem_valid);
        end
    endtask

    task automatic test_dc_store;
        dc_req_valid = 1; dc_req_we = 1; dc_req_addr = 32'h40; dc_req_wdata = 32'hDEAD_BEEF;
        step;
        total++;
        if ({dc_req_ready, ic_req_ready, mem_valid, mem_we, mem_addr, mem_wdata} !==
            {4'b1011, 32'h40, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL dc_store_grant: got ready=%b/%b valid=%b we=%b addr=%h wdata=%h",
                dc_req_ready, ic_req_ready, mem_valid, mem_we, mem_addr, mem_wdata);
        end
        dc_req_valid = 0; dc_req_we = 0; dc_req_addr = 0; dc_req_wdata = 0;
        mem_ready = 1;
        step;
        mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            step;
            total++;
            if ({dc_resp_valid, mem_valid} !== 2'b0) begin
                bad++; $display("FAIL dc_store_wait%0d: got v=%b mv=%b want 0 0", i, dc_resp_valid, mem_valid);
            end
        end
        mem_wack = 1;
        step;
        mem_wack = 0;
        total++;
        if ({dc_resp_valid, dc_resp_last, dc_resp_data, ic_resp_valid} !== {2'b11, 32'h0, 1'b0}) begin
            bad++; $display("FAIL dc_store_ack: got v=%b l=%b d=%h icv=%b want 1 1 0 0",
                dc_resp_valid, dc_resp_last, dc_resp_data, ic_resp_valid);
        end
        step;
        total++;
        if ({dc_resp_valid, dc_resp_last} !== 2'b0) begin
            bad++; $display("FAIL dc_store_pulse: got v=%b l=%b want 0 0", dc_resp_valid, dc_resp_last);
        end
    endtask

    task automatic test_simultaneous;
        do_reset;
        ic_req_valid = 1; ic_req_addr = 32'h100;
        dc_req_valid = 1; dc_req_we = 0; dc_req_addr = 32'h205;
        step;
        total++;
        if ({dc_req_ready, ic_req_ready, mem_addr} !== {2'b10, 32'h200}) begin
            bad++; $display("FAIL sim_first_dc: got dc=%b ic=%b addr=%h want 1 0 00000200",
                dc_req_ready, ic_req_ready, mem_addr);
        end
        dc_req_valid = 0;
        mem_ready = 1;
        step;
        mem_ready = 0;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1; mem_rdata = 32'hA0 + i;
            step;
            total++;
            if ({dc_resp_valid, dc_resp_last, dc_resp_data, ic_resp_valid, ic_req_ready} !==
                {1'b1, 1'(i == 7), 32'hA0 + 32'(i), 2'b00}) begin
                bad++; $display("FAIL sim_dc_beat%0d: got v=%b l=%b d=%h icv=%b icr=%b",
                    i, dc_resp_valid, dc_resp_last, dc_resp_data, ic_resp_valid, ic_req_ready);
            end
        end
        mem_rvalid = 0;
        dc_req_valid = 1;
        step;
        total++;
        if ({ic_req_ready, dc_req_ready, mem_valid} !== 3'b0) begin
            bad++; $display("FAIL sim_no_grant_on_done: got icr=%b dcr=%b mv=%b want 0 0 0",
                ic_req_ready, dc_req_ready, mem_valid);
        end
        step;
`ifdef MEM_ARB_DPRIO_EN
        total++;
        if ({dc_req_ready, ic_req_ready, mem_valid, mem_addr} !== {3'b101, 32'h200}) begin
            bad++; $display("FAIL sim_second_grant: got dc=%b ic=%b mv=%b addr=%h want 1 0 1 00000200",
                dc_req_ready, ic_req_ready, mem_valid, mem_addr);
        end
`else
        total++;
        if ({dc_req_ready, ic_req_ready, mem_valid, mem_addr} !== {3'b011, 32'h100}) begin
            bad++; $display("FAIL sim_second_grant: got dc=%b ic=%b mv=%b addr=%h want 0 1 1 00000100",
                dc_req_ready, ic_req_ready, mem_valid, mem_addr);
        end
`endif
        ic_req_valid = 0; dc_req_valid = 0;
    endtask

    task automatic test_back_to_back;
        int k;
        logic got_dc, want_dc;
        do_reset;
        ic_req_valid = 1; ic_req_addr = 32'h100;
        dc_req_valid = 1; dc_req_we = 0; dc_req_addr = 32'h200;
        for (int n = 0; n < 4; n++) begin
            k = 0;
            while (!(ic_req_ready || dc_req_ready) && k < 10) begin
                step;
                k++;
            end
            if (k == 10) begin
                total++; bad++;
                $display("FAIL b2b_grant%0d: no req_ready within 10 cycles", n);
                break;
            end
            got_dc = dc_req_ready;
`ifdef MEM_ARB_DPRIO_EN
            want_dc = 1'b1;
`else
            want_dc = (n % 2 == 0);
`endif
            total++;
            if (got_dc !== want_dc) begin
                bad++; $display("FAIL b2b_order%0d: got dc_granted=%b want %b", n, got_dc, want_dc);
            end
            mem_ready = 1;
            step;
            mem_ready = 0;
            for (int i = 0; i < 8; i++) begin
                mem_rvalid = 1; mem_rdata = 32'(n * 16 + i);
                step;
            end
            mem_rvalid = 0;
        end
        ic_req_valid = 0; dc_req_valid = 0;
    endtask

    task automatic test_reset_midburst;
        do_reset;
        ic_req_valid = 1; ic_req_addr = 32'h3000;
        step;
        ic_req_valid = 0;
        mem_ready = 1;
        step;
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1; mem_rdata = 32'h10 + i;
            step;
        end
        total++;
        if ({ic_resp_valid, ic_resp_data} !== {1'b1, 32'h12}) begin
            bad++; $display("FAIL rst_pre_beat2: got v=%b d=%h want 1 00000012", ic_resp_valid, ic_resp_data);
        end
        mem_rdata = 32'h13;
        RST = 1;
        #1;
        total++;
        if ({ic_resp_valid, ic_resp_last, ic_resp_data, ic_req_ready, mem_valid, mem_addr} !== 68'b0) begin
            bad++; $display("FAIL rst_async: got v=%b l=%b d=%h r=%b mv=%b addr=%h want all 0",
                ic_resp_valid, ic_resp_last, ic_resp_data, ic_req_ready, mem_valid, mem_addr);
        end
        step;
        RST = 0; mem_rvalid = 0;
        step;
        total++;
        if ({ic_resp_valid, mem_valid} !== 2'b0) begin
            bad++; $display("FAIL rst_abandon: got v=%b mv=%b want 0 0", ic_resp_valid, mem_valid);
        end
        ic_req_valid = 1;
        step;
        total++;
        if ({ic_req_ready, mem_valid, mem_addr} !== {2'b11, 32'h3000}) begin
            bad++; $display("FAIL rst_regrant: got r=%b mv=%b addr=%h want 1 1 00003000",
                ic_req_ready, mem_valid, mem_addr);
        end
        ic_req_valid = 0;
        mem_ready = 1;
        step;
        mem_ready = 0;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1; mem_rdata = 32'h50 + i;
            step;
            total++;
            if ({ic_resp_valid, ic_resp_last, ic_resp_data} !== {1'b1, 1'(i == 7), 32'h50 + 32'(i)}) begin
                bad++; $display("FAIL rst_restart_beat%0d: got v=%b l=%b d=%h want v=1 l=%b",
                    i, ic_resp_valid, ic_resp_last, ic_resp_data, (i == 7));
            end
        end
        mem_rvalid = 0;
        step;
    endtask

    task automatic test_stray;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1; mem_wack = 1; mem_rdata = 32'hFFFF_FFFF;
            step;
            total++;
            if ({ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last, mem_valid, dc_resp_data} !== 37'b0) begin
                bad++; $display("FAIL stray%0d: got icv=%b dcv=%b icl=%b dcl=%b mv=%b dcd=%h want all 0",
                    i, ic_resp_valid, dc_resp_valid, ic_resp_last, dc_resp_last, mem_valid, dc_resp_data);
            end
        end
        mem_rvalid = 0; mem_wack = 0; mem_rdata = 0;
    endtask

    initial begin
        test_reset;
        test_ic_read;
        test_dc_store;
        test_simultaneous;
        test_back_to_back;
        test_reset_midburst;
        test_stray;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
